// File: rtl/spi_ip_sr_engine.sv
// SPI shift-register engine: parallel load, bit-serial TX/RX, 1..W bit frames.
// Strobe-driven launch/capture with abort, load-reject and completion pulses.
module spi_ip_sr_engine #(
    parameter int   PARAM_SR_WIDTH   = 16,
    parameter int   PARAM_LEN_W      = 5,
    parameter logic PARAM_IDLE_LEVEL = 1'b0
) (
    input  logic                      sre_clk_i,
    input  logic                      sre_rst_i,
    input  logic                      sre_load_i,
    input  logic [PARAM_SR_WIDTH-1:0] sre_data_load_i,
    input  logic [PARAM_LEN_W-1:0]    sre_len_i,
    input  logic                      sre_lsb_first_i,
    input  logic                      sre_en_i,
    input  logic                      sre_launch_i,
    input  logic                      sre_capture_i,
    input  logic                      sre_abort_i,
    input  logic                      sre_serial_i,
    output logic                      sre_serial_o,
    output logic [PARAM_SR_WIDTH-1:0] sre_data_out_o,
    output logic                      sre_data_ready_o,
    output logic                      sre_busy_o,
    output logic                      sre_load_err_o
);

    localparam int W  = PARAM_SR_WIDTH;
    localparam int LW = PARAM_LEN_W;
    localparam logic [LW-1:0] W_L = LW'(W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  tx_q, tx_d;
    logic [W-1:0]  rx_q, rx_d;
    logic [W-1:0]  dout_q, dout_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] txrem_q, txrem_d;
    logic          lsb_q, lsb_d;
    logic          ser_q, ser_d;
    logic          rdy_q, rdy_d;
    logic          err_q, err_d;

    logic [LW-1:0] len_n;
    logic [W-1:0]  rx_shift;
    logic          launch;
    logic          capture;

    // Normalise requested length: 0 or oversize means a full-width frame.
    always_comb begin
        len_n = sre_len_i;
        if (sre_len_i == '0 || sre_len_i > W_L) begin
            len_n = W_L;
        end
    end

    assign launch   = sre_en_i & sre_launch_i;
    assign capture  = sre_en_i & sre_capture_i;
    // RX shifts toward the end the first bit must finally occupy.
    assign rx_shift = lsb_q ? {sre_serial_i, rx_q[W-1:1]}
                            : {rx_q[W-2:0], sre_serial_i};

    // Next-state and datapath decisions for the IDLE/SHIFT machine.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        txrem_d = txrem_q;
        lsb_d   = lsb_q;
        ser_d   = ser_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ser_d = PARAM_IDLE_LEVEL;
                if (sre_load_i) begin
                    state_d = SHIFT;
                    len_d   = len_n;
                    lsb_d   = sre_lsb_first_i;
                    cnt_d   = len_n;
                    txrem_d = len_n - LW'(1);
                    rx_d    = '0;
                    if (sre_lsb_first_i) begin
                        tx_d  = sre_data_load_i;
                        ser_d = sre_data_load_i[0];
                    end else begin
                        tx_d  = sre_data_load_i << (W_L - len_n);
                        ser_d = tx_d[W-1];
                    end
                end
            end
            SHIFT: begin
                err_d = sre_load_i;
                if (sre_abort_i) begin
                    state_d = IDLE;
                    ser_d   = PARAM_IDLE_LEVEL;
                    cnt_d   = '0;
                end else begin
                    if (launch) begin
                        if (txrem_q != '0) begin
                            txrem_d = txrem_q - LW'(1);
                            if (lsb_q) begin
                                tx_d  = tx_q >> 1;
                                ser_d = tx_q[1];
                            end else begin
                                tx_d  = tx_q << 1;
                                ser_d = tx_q[W-2];
                            end
                        end else begin
                            ser_d = PARAM_IDLE_LEVEL;
                        end
                    end
                    if (capture) begin
                        rx_d  = rx_shift;
                        cnt_d = cnt_q - LW'(1);
                        if (cnt_q == LW'(1)) begin
                            dout_d  = lsb_q ? (rx_shift >> (W_L - len_q))
                                            : rx_shift;
                            state_d = IDLE;
                            rdy_d   = 1'b1;
                            ser_d   = PARAM_IDLE_LEVEL;
                        end
                    end
                end
            end
        endcase
    end

    // State register with asynchronous reset to the idle condition.
    always_ff @(posedge sre_clk_i or posedge sre_rst_i) begin
        if (sre_rst_i) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            txrem_q <= '0;
            lsb_q   <= 1'b0;
            ser_q   <= PARAM_IDLE_LEVEL;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            txrem_q <= txrem_d;
            lsb_q   <= lsb_d;
            ser_q   <= ser_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    assign sre_serial_o     = ser_q;
    assign sre_data_out_o   = dout_q;
    assign sre_data_ready_o = rdy_q;
    assign sre_busy_o       = (state_q == SHIFT);
    assign sre_load_err_o   = err_q;

endmodule

// File: tb/tb_spi_ip_sr_engine.sv
// Bench for spi_ip_sr_engine: bit-indexed frame model checked every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_spi_ip_sr_engine;

    localparam logic IDLE = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [4:0]  len;
    logic        lsb;
    logic        en;
    logic        launch;
    logic        cap;
    logic        abort;
    logic        sin;
    logic        sout;
    logic [15:0] dout;
    logic        rdy;
    logic        busy;
    logic        lerr;

    int nvec = 0;
    int nerr = 0;

    spi_ip_sr_engine #(
        .PARAM_SR_WIDTH  (16),
        .PARAM_LEN_W     (5),
        .PARAM_IDLE_LEVEL(IDLE)
    ) dut (
        .sre_clk_i       (clk),
        .sre_rst_i       (rst),
        .sre_load_i      (load),
        .sre_data_load_i (data),
        .sre_len_i       (len),
        .sre_lsb_first_i (lsb),
        .sre_en_i        (en),
        .sre_launch_i    (launch),
        .sre_capture_i   (cap),
        .sre_abort_i     (abort),
        .sre_serial_i    (sin),
        .sre_serial_o    (sout),
        .sre_data_out_o  (dout),
        .sre_data_ready_o(rdy),
        .sre_busy_o      (busy),
        .sre_load_err_o  (lerr)
    );

    always #5 clk = ~clk;

    // Frame model: word, length, bits launched so far, bits captured so far.
    logic        m_busy;
    logic [15:0] m_word;
    int          m_L;
    logic        m_lsb;
    int          m_sent;
    int          m_k;
    logic [15:0] m_rx;
    logic [15:0] m_dout;
    logic        m_rdy;
    logic        m_err;
    logic        m_ser;

    function automatic logic txbit(int i);
        return m_lsb ? m_word[i] : m_word[m_L-1-i];
    endfunction

    task automatic model_reset();
        m_busy = 0; m_word = 0; m_L = 0; m_lsb = 0; m_sent = 0;
        m_k = 0; m_rx = 0; m_dout = 0; m_rdy = 0; m_err = 0;
        m_ser = IDLE;
    endtask

    task automatic model_step();
        int pos;
        m_rdy = 0;
        m_err = 0;
        if (!m_busy) begin
            m_ser = IDLE;
            if (load) begin
                m_L    = (len == 0 || len > 16) ? 16 : int'(len);
                m_busy = 1; m_word = data; m_lsb = lsb;
                m_sent = 1; m_k = 0; m_rx = 0;
                m_ser  = txbit(0);
            end
        end else begin
            m_err = load;
            if (abort) begin
                m_busy = 0;
                m_ser  = IDLE;
            end else begin
                if (en && launch) begin
                    if (m_sent < m_L) begin
                        m_ser = txbit(m_sent);
                        m_sent++;
                    end else begin
                        m_ser = IDLE;
                    end
                end
                if (en && cap) begin
                    pos = m_lsb ? m_k : m_L - 1 - m_k;
                    m_rx[pos] = sin;
                    m_k++;
                    if (m_k == m_L) begin
                        m_dout = m_rx; m_rdy = 1; m_busy = 0; m_ser = IDLE;
                    end
                end
            end
        end
    endtask

    task automatic cmp(string nm, logic [31:0] a, logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic check_all();
        cmp("serial_o", 32'(sout), 32'(m_ser));
        cmp("data_out", 32'(dout), 32'(m_dout));
        cmp("ready",    32'(rdy),  32'(m_rdy));
        cmp("busy",     32'(busy), 32'(m_busy));
        cmp("load_err", 32'(lerr), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_in();
        load = 0; abort = 0; launch = 0; cap = 0; en = 1;
    endtask

    task automatic frame(input logic [15:0] word, input logic [4:0] ln,
                         input logic lf, input logic [15:0] rxw,
                         input int nb, output logic [15:0] seen);
        load = 1; data = word; len = ln; lsb = lf;
        tick();
        load = 0;
        seen = 0;
        for (int i = 0; i < nb; i++) begin
            seen[lf ? i : nb-1-i] = sout;
            sin = lf ? rxw[i] : rxw[nb-1-i];
            en = 1; launch = 1; cap = 1;
            tick();
        end
        idle_in();
    endtask

    logic [15:0] seen;

    initial begin
        rst = 1; data = 0; len = 0; lsb = 0; sin = 0;
        idle_in();
        model_reset();
        @(negedge clk);
        check_all();
        cmp("reset_busy", 32'(busy), 32'd0);
        cmp("reset_ser",  32'(sout), 32'(IDLE));
        rst = 0;
        tick();

        // L=8 MSB-first, upper TX bits ignored.
        frame(16'hFF12, 5'd8, 1'b0, 16'h0034, 8, seen);
        cmp("l8_tx",    32'(seen[7:0]), 32'h12);
        cmp("l8_dout",  32'(dout), 32'h0034);
        cmp("l8_ready", 32'(rdy), 32'd1);
        cmp("l8_model", 32'(m_dout), 32'h0034);
        tick();
        cmp("l8_ready_drop", 32'(rdy), 32'd0);

        // Length 0 means a full 16-bit frame.
        frame(16'hA5C3, 5'd0, 1'b0, 16'h0F0F, 16, seen);
        cmp("len0_tx",   32'(seen), 32'hA5C3);
        cmp("len0_dout", 32'(dout), 32'h0F0F);

        // Loopback equivalents, MSB-first then LSB-first.
        frame(16'h1234, 5'd16, 1'b0, 16'h5678, 16, seen);
        cmp("lb_msb_tx",   32'(seen), 32'h1234);
        cmp("lb_msb_dout", 32'(dout), 32'h5678);
        frame(16'h1E6A, 5'd16, 1'b1, 16'hA6E1, 16, seen);
        cmp("lb_lsb_tx",   32'(seen), 32'h1E6A);
        cmp("lb_lsb_dout", 32'(dout), 32'hA6E1);
        tick();

        // Rejected load and enable gating mid-frame.
        load = 1; data = 16'hBEEF; len = 5'd16; lsb = 0;
        tick();
        load = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                idle_in(); load = 1; data = 16'h0000;
                tick();
                cmp("rej_err", 32'(lerr), 32'd1);
                load = 0;
                for (int j = 0; j < 5; j++) begin
                    en = 0; launch = 1; cap = 1; sin = 1'($urandom);
                    tick();
                end
                cmp("gate_busy", 32'(busy), 32'd1);
            end
            sin = 16'h1357 >> (15 - i);
            en = 1; launch = 1; cap = 1;
            tick();
        end
        idle_in();
        cmp("gate_dout",  32'(dout), 32'h1357);
        cmp("gate_ready", 32'(rdy), 32'd1);

        // Abort after five captures keeps the previous word.
        load = 1; data = 16'h0F0F; len = 5'd16; lsb = 0;
        tick();
        load = 0;
        for (int i = 0; i < 5; i++) begin
            sin = 1'($urandom); launch = 1; cap = 1;
            tick();
        end
        abort = 1;
        tick();
        idle_in();
        cmp("abort_busy", 32'(busy), 32'd0);
        cmp("abort_rdy",  32'(rdy), 32'd0);
        cmp("abort_dout", 32'(dout), 32'h1357);
        cmp("abort_ser",  32'(sout), 32'(IDLE));
        tick();

        // Asynchronous reset mid-frame, observed between edges.
        load = 1; data = 16'h3C3C; len = 5'd12; lsb = 1;
        tick();
        load = 0;
        for (int i = 0; i < 3; i++) begin
            sin = 1'($urandom); launch = 1; cap = 1;
            tick();
        end
        idle_in();
        #2 rst = 1;
        #1;
        model_reset();
        cmp("arst_busy", 32'(busy), 32'd0);
        cmp("arst_dout", 32'(dout), 32'd0);
        cmp("arst_ser",  32'(sout), 32'(IDLE));
        cmp("arst_rdy",  32'(rdy), 32'd0);
        cmp("arst_err",  32'(lerr), 32'd0);
        @(negedge clk);
        rst = 0;
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            load   = ($urandom_range(0, 11) == 0);
            abort  = ($urandom_range(0, 39) == 0);
            en     = ($urandom_range(0, 99) < 85);
            launch = 1'($urandom);
            cap    = 1'($urandom);
            sin    = 1'($urandom);
            data   = 16'($urandom);
            len    = 5'($urandom);
            lsb    = 1'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
